// File: rtl/otter_pkg.sv
// -----------------------------------------------------------------------------
// otter_pkg
// Shared definitions for the OTTER memory arbiter slice.
//   owner_t            : which requester owns the access in flight
//   STARVE_MAX_DEFAULT : denied fetch cycles before fetch wins priority
//   FETCH_SIZE/SIGN    : access shape driven to memory for instruction fetches
// -----------------------------------------------------------------------------
package otter_pkg;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_IF   = 2'd1,
      OWNER_DATA = 2'd2
   } owner_t;

   localparam int STARVE_MAX_DEFAULT = 4;

   // Instruction fetches are always full, unsigned words.
   localparam logic [1:0] FETCH_SIZE = 2'b10;
   localparam logic       FETCH_SIGN = 1'b0;

endpackage

// File: rtl/otter_sat_counter.sv
// -----------------------------------------------------------------------------
// otter_sat_counter
// Saturating up-counter with synchronous clear.
//   CLK      in   clock
//   RESET    in   synchronous active-high reset, clears the count
//   i_inc    in   increment request (ignored once the count reaches MAX)
//   i_clr    in   clear request, wins over i_inc
//   o_count  out  current count, 0..MAX
// -----------------------------------------------------------------------------
module otter_sat_counter #(
   parameter int MAX = 4,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_count
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] r_count;

   always_ff @(posedge CLK) begin
      if (RESET || i_clr)
         r_count <= '0;
      else if (i_inc && (r_count != MAX_V))
         r_count <= r_count + 1'b1;
   end

   assign o_count = r_count;

endmodule

// File: rtl/otter_mem_arbiter.sv
// -----------------------------------------------------------------------------
// otter_mem_arbiter
// Shares one single-port memory between the fetch stage and the MEM stage.
// Data normally wins; a fetch denied STARVE_MAX cycles in a row wins the next
// cycle it asks. Grants are combinational, responses come back one cycle later.
//   CLK, RESET                          clock, synchronous active-high reset
//   i_if_req/i_if_addr/i_if_flush       fetch request, PC, discard response
//   o_if_gnt/o_if_valid/o_if_rdata      fetch grant, response valid, data
//   i_d_req/i_d_we/i_d_addr/i_d_wdata   data request, store flag, addr, data
//   i_d_size/i_d_sign                   access width, load sign-extend
//   o_d_gnt/o_d_valid/o_d_rdata         data grant, load data / store ack
//   o_mem_re/we/addr/din/size/sign      memory request (zero when idle)
//   i_mem_dout                          memory read data, one cycle after re
//   o_stall_if/o_stall_mem              requester denied this cycle
// -----------------------------------------------------------------------------
module otter_mem_arbiter
   import otter_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        i_if_req,
   input  logic [31:0] i_if_addr,
   input  logic        i_if_flush,
   output logic        o_if_gnt,
   output logic        o_if_valid,
   output logic [31:0] o_if_rdata,
   input  logic        i_d_req,
   input  logic        i_d_we,
   input  logic [31:0] i_d_addr,
   input  logic [31:0] i_d_wdata,
   input  logic [1:0]  i_d_size,
   input  logic        i_d_sign,
   output logic        o_d_gnt,
   output logic        o_d_valid,
   output logic [31:0] o_d_rdata,
   output logic        o_mem_re,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_din,
   output logic [1:0]  o_mem_size,
   output logic        o_mem_sign,
   input  logic [31:0] i_mem_dout,
   output logic        o_stall_if,
   output logic        o_stall_mem
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_V = CW'(STARVE_MAX);

   owner_t        r_owner;
   logic [CW-1:0] w_starve_cnt;
   logic          w_starved;
   logic          w_if_gnt;
   logic          w_d_gnt;
   logic          w_if_valid;
   logic          w_d_valid;

   // Counts consecutive cycles the fetch stage asked and was refused.
   otter_sat_counter #(
      .MAX (STARVE_MAX),
      .W   (CW)
   ) u_starve_cnt (
      .CLK     (CLK),
      .RESET   (RESET),
      .i_inc   (i_if_req && !w_if_gnt),
      .i_clr   (w_if_gnt || !i_if_req),
      .o_count (w_starve_cnt)
   );

   assign w_starved = (w_starve_cnt == STARVE_V);

   // The two grants are complementary by construction: fetch only wins when
   // data is absent or fetch is starved, and data yields in exactly that case.
   assign w_if_gnt = !RESET && i_if_req && (!i_d_req || w_starved);
   assign w_d_gnt  = !RESET && i_d_req  && !(w_starved && i_if_req);

   always_comb begin
      o_mem_re   = 1'b0;
      o_mem_we   = 1'b0;
      o_mem_addr = '0;
      o_mem_din  = '0;
      o_mem_size = '0;
      o_mem_sign = 1'b0;
      if (w_if_gnt) begin
         o_mem_re   = 1'b1;
         o_mem_addr = i_if_addr;
         o_mem_size = FETCH_SIZE;
         o_mem_sign = FETCH_SIGN;
      end else if (w_d_gnt) begin
         o_mem_re   = !i_d_we;
         o_mem_we   = i_d_we;
         o_mem_addr = i_d_addr;
         o_mem_din  = i_d_wdata;
         o_mem_size = i_d_size;
         o_mem_sign = i_d_sign;
      end
   end

   // Owner of the access whose response returns next cycle.
   always_ff @(posedge CLK) begin
      if (RESET)
         r_owner <= OWNER_NONE;
      else if (w_if_gnt)
         r_owner <= OWNER_IF;
      else if (w_d_gnt)
         r_owner <= OWNER_DATA;
      else
         r_owner <= OWNER_NONE;
   end

   // A flush only kills the fetch response returning now; a fetch granted in
   // the same cycle is recorded in r_owner and returns normally.
   assign w_if_valid = !RESET && (r_owner == OWNER_IF) && !i_if_flush;
   assign w_d_valid  = !RESET && (r_owner == OWNER_DATA);

   assign o_if_gnt    = w_if_gnt;
   assign o_d_gnt     = w_d_gnt;
   assign o_if_valid  = w_if_valid;
   assign o_d_valid   = w_d_valid;
   assign o_if_rdata  = w_if_valid ? i_mem_dout : 32'd0;
   assign o_d_rdata   = w_d_valid  ? i_mem_dout : 32'd0;
   assign o_stall_if  = !RESET && i_if_req && !w_if_gnt;
   assign o_stall_mem = !RESET && i_d_req  && !w_d_gnt;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_otter_mem_arbiter
// Directed bench for otter_mem_arbiter. Each step drives one cycle of inputs
// with its expected grants; responses owed by a grant are queued and checked
// in the following cycle against a simple registered memory model.
// -----------------------------------------------------------------------------
module tb_otter_mem_arbiter;

   localparam logic [31:0] JUNK = 32'h5EED_5EED;

   typedef struct {
      bit          is_if;
      bit          is_store;
      logic [31:0] addr;
   } resp_t;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        if_req, if_flush, d_req, d_we, d_sign;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [1:0]  d_size;
   logic        if_gnt, if_valid, d_gnt, d_valid;
   logic [31:0] if_rdata, d_rdata;
   logic        mem_re, mem_we, mem_sign, stall_if, stall_mem;
   logic [31:0] mem_addr, mem_din, mem_dout;
   logic [1:0]  mem_size;

   int    checks   = 0;
   int    failures = 0;
   resp_t pend[$];

   always #5 CLK = ~CLK;

   otter_mem_arbiter #(.STARVE_MAX(4)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .i_if_req    (if_req),
      .i_if_addr   (if_addr),
      .i_if_flush  (if_flush),
      .o_if_gnt    (if_gnt),
      .o_if_valid  (if_valid),
      .o_if_rdata  (if_rdata),
      .i_d_req     (d_req),
      .i_d_we      (d_we),
      .i_d_addr    (d_addr),
      .i_d_wdata   (d_wdata),
      .i_d_size    (d_size),
      .i_d_sign    (d_sign),
      .o_d_gnt     (d_gnt),
      .o_d_valid   (d_valid),
      .o_d_rdata   (d_rdata),
      .o_mem_re    (mem_re),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_din   (mem_din),
      .o_mem_size  (mem_size),
      .o_mem_sign  (mem_sign),
      .i_mem_dout  (mem_dout),
      .o_stall_if  (stall_if),
      .o_stall_mem (stall_mem)
   );

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Read data appears one cycle after a read; otherwise a recognisable filler.
   initial mem_dout = JUNK;
   always @(posedge CLK) mem_dout <= mem_re ? mem_val(mem_addr) : JUNK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input bit rst,
                       input bit ifr, input logic [31:0] ifa, input bit flush,
                       input bit dr, input bit dwe, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [1:0] dsz, input bit dsg,
                       input bit e_ig, input bit e_dg);
      resp_t       r;
      bit          have;
      logic        e_ifv, e_dv, e_re, e_we, e_sign;
      logic [31:0] e_ifd, e_dd, e_addr, e_din;
      logic [1:0]  e_size;
      RESET = rst; if_req = ifr; if_addr = ifa; if_flush = flush;
      d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_size = dsz; d_sign = dsg;
      #1;
      have = (pend.size() > 0);
      r = '{is_if: 1'b0, is_store: 1'b0, addr: 32'd0};
      if (have) r = pend.pop_front();
      e_ifv = have && r.is_if && !flush && !rst;
      e_dv  = have && !r.is_if && !rst;
      e_ifd = e_ifv ? mem_val(r.addr) : 32'd0;
      e_dd  = e_dv ? (r.is_store ? JUNK : mem_val(r.addr)) : 32'd0;
      e_re = 1'b0; e_we = 1'b0; e_addr = 32'd0; e_din = 32'd0; e_size = 2'd0; e_sign = 1'b0;
      if (e_ig) begin
         e_re = 1'b1; e_addr = ifa; e_size = 2'b10;
      end else if (e_dg) begin
         e_re = !dwe; e_we = dwe; e_addr = da; e_din = dwd; e_size = dsz; e_sign = dsg;
      end
      chk({tag, ".if_gnt"},    32'(if_gnt),    32'(e_ig));
      chk({tag, ".d_gnt"},     32'(d_gnt),     32'(e_dg));
      chk({tag, ".mem_re"},    32'(mem_re),    32'(e_re));
      chk({tag, ".mem_we"},    32'(mem_we),    32'(e_we));
      chk({tag, ".mem_addr"},  mem_addr,       e_addr);
      chk({tag, ".mem_din"},   mem_din,        e_din);
      chk({tag, ".mem_size"},  32'(mem_size),  32'(e_size));
      chk({tag, ".mem_sign"},  32'(mem_sign),  32'(e_sign));
      chk({tag, ".stall_if"},  32'(stall_if),  32'(ifr && !e_ig && !rst));
      chk({tag, ".stall_mem"}, 32'(stall_mem), 32'(dr && !e_dg && !rst));
      chk({tag, ".if_valid"},  32'(if_valid),  32'(e_ifv));
      chk({tag, ".if_rdata"},  if_rdata,       e_ifd);
      chk({tag, ".d_valid"},   32'(d_valid),   32'(e_dv));
      chk({tag, ".d_rdata"},   d_rdata,        e_dd);
      $display("step %-10s rst=%0b if_req=%0b d_req=%0b if_gnt=%0b d_gnt=%0b if_valid=%0b d_valid=%0b",
               tag, rst, ifr, dr, if_gnt, d_gnt, if_valid, d_valid);
      if (e_ig)
         pend.push_back('{is_if: 1'b1, is_store: 1'b0, addr: ifa});
      else if (e_dg)
         pend.push_back('{is_if: 1'b0, is_store: dwe, addr: da});
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_size = 0; d_sign = 0;
      @(posedge CLK);
      #1;
      // Reset holds everything low even with both requests up.
      step("rst0", 1, 1, 32'h100, 0, 1, 0, 32'h2000, 0, 2'd2, 0, 0, 0);
      step("rst1", 1, 1, 32'h100, 0, 1, 1, 32'h2000, 32'h1, 2'd2, 0, 0, 0);
      // Lone fetch, then its response.
      step("fetch",  0, 1, 32'h100, 0, 0, 0, 32'h0, 0, 2'd0, 0, 1, 0);
      step("idle1",  0, 0, 32'h0,   0, 0, 0, 32'h0, 0, 2'd0, 0, 0, 0);
      // Data beats fetch when both request.
      step("both",   0, 1, 32'h104, 0, 1, 0, 32'h2000, 0, 2'd2, 0, 0, 1);
      step("idle2",  0, 0, 32'h0,   0, 0, 0, 32'h0, 0, 2'd0, 0, 0, 0);
      // Starvation: four data grants, then fetch, then data again.
      for (int i = 0; i < 6; i++)
         step($sformatf("starve%0d", i + 1), 0, 1, 32'h200, 0, 1, 0,
              32'h2010 + 32'(4 * i), 0, 2'd2, 0, (i == 4), (i != 4));
      // Flush kills the returning fetch only; the fetch granted alongside returns.
      step("fetchN",  0, 1, 32'h300, 0, 0, 0, 32'h0, 0, 2'd0, 0, 1, 0);
      step("flushN1", 0, 1, 32'h304, 1, 0, 0, 32'h0, 0, 2'd0, 0, 1, 0);
      step("fetchN2", 0, 0, 32'h0,   0, 0, 0, 32'h0, 0, 2'd0, 0, 0, 0);
      // Store, acknowledged next cycle with no read issued.
      step("store",   0, 0, 32'h0, 0, 1, 1, 32'h3000, 32'hDEADBEEF, 2'd2, 0, 0, 1);
      step("storeack",0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 2'd0, 0, 0, 0);
      // Signed half-word load; a flush during its response must not matter.
      step("ldh",     0, 0, 32'h0, 0, 1, 0, 32'h2100, 0, 2'd1, 1, 0, 1);
      step("ldhflush",0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 2'd0, 0, 0, 0);
      // Build up starvation, reset mid-load, and confirm a fresh count afterwards.
      for (int i = 0; i < 3; i++)
         step($sformatf("pre%0d", i), 0, 1, 32'h400, 0, 1, 0,
              32'h2200 + 32'(4 * i), 0, 2'd2, 0, 0, 1);
      step("rstmid", 1, 1, 32'h400, 0, 1, 0, 32'h2300, 0, 2'd2, 0, 0, 0);
      for (int i = 0; i < 5; i++)
         step($sformatf("post%0d", i), 0, 1, 32'h500, 0, 1, 0,
              32'h2400 + 32'(4 * i), 0, 2'd2, 0, (i == 4), (i != 4));
      step("drain", 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 2'd0, 0, 0, 0);
      chk("queue_empty", 32'(pend.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/otter_mem_arbiter.md
OTTER_MEM_ARBITER -- requirements
Module: otter_mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive denied fetch cycles after which fetch wins priority.
REQ-002 CLK  in  1  clock; all state updates on rising edge.
REQ-003 RESET  in  1  synchronous, active-high.
REQ-004 if_req  in  1  fetch stage requests an instruction read.
REQ-005 if_addr  in  32  fetch byte address (PC).
REQ-006 if_flush  in  1  branch taken; discard in-flight fetch response.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_valid  out  1  fetch data valid this cycle.
REQ-009 if_rdata  out  32  fetched instruction.
REQ-010 d_req  in  1  MEM-stage access request.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_addr  in  32  data byte address.
REQ-013 d_wdata  in  32  store data.
REQ-014 d_size  in  2  byte/half/word; d_sign  in  1  load sign-extend.
REQ-015 d_gnt  out  1  data request accepted this cycle.
REQ-016 d_valid  out  1  load data ready or store acknowledged.
REQ-017 d_rdata  out  32  load data.
REQ-018 mem_re, mem_we  out  1 each; mem_addr, mem_din  out  32; mem_size  out  2; mem_sign  out  1: single-port memory request.
REQ-019 mem_dout  in  32  memory read data, one cycle after mem_re.
REQ-020 stall_if, stall_mem  out  1 each: pipeline stall requests.

Function
REQ-021 At most one of if_gnt, d_gnt SHALL be high in any cycle.
REQ-022 Priority: data over fetch, unless starve_cnt == STARVE_MAX and if_req, then fetch is granted.
REQ-023 Grant is combinational; the granted requester's address/data/size/sign SHALL drive mem_* in the same cycle; mem_re = grant && !write, mem_we = d_gnt && d_we.
REQ-024 No grant: mem_re = mem_we = 0; mem_addr, mem_din, mem_size, mem_sign = 0.
REQ-025 stall_if = if_req && !if_gnt; stall_mem = d_req && !d_gnt.
REQ-026 Owner register {NONE, IF, DATA} SHALL record the granted requester each cycle (NONE if no grant).
REQ-027 Latency: if_valid / d_valid SHALL pulse exactly one cycle after the grant, for owner IF / DATA respectively; store ack also one cycle after grant.
REQ-028 if_rdata = mem_dout and d_rdata = mem_dout when the respective valid is high; otherwise both 0.
REQ-029 Back-to-back: a new grant in the cycle a response returns SHALL be allowed (one access per cycle, full throughput).
REQ-030 starve_cnt (width sized to STARVE_MAX): increments when if_req && !if_gnt, saturates at STARVE_MAX, clears on if_gnt or !if_req.
REQ-031 if_flush high in a cycle with owner IF SHALL suppress if_valid for that response; a fetch granted in that same cycle SHALL be unaffected.
REQ-032 if_flush has no effect on data transactions or starve_cnt.
REQ-033 Requests with no request line high SHALL leave memory idle; req held across stall SHALL be re-arbitrated each cycle with current inputs.

Reset
REQ-034 RESET SHALL set owner = NONE, starve_cnt = 0; all grants, valids, stalls, mem_re, mem_we = 0 while RESET high.
REQ-035 Reset mid-transaction SHALL drop the in-flight response (no valid in the cycle after reset deasserts).

Structure
REQ-036 Owner enum and STARVE_MAX default SHALL reside in shared package otter_pkg.
REQ-037 Starvation counter SHALL be a sub-module otter_sat_counter (increment, clear, saturate, parameter MAX).

Verification
REQ-038 if_req=1, if_addr=0x100, d_req=0 -> if_gnt same cycle, mem_re=1, mem_addr=0x100; next cycle if_valid=1, if_rdata=mem_dout.
REQ-039 if_req=1 and d_req=1, d_we=0, d_addr=0x2000 same cycle -> d_gnt=1, stall_if=1; next cycle d_valid=1, if_valid=0.
REQ-040 d_req held 6 cycles with if_req=1, STARVE_MAX=4 -> d_gnt cycles 1-4, if_gnt cycle 5 (stall_mem=1), d_gnt cycle 6.
REQ-041 Fetch granted at cycle N, if_flush=1 at N+1 -> if_valid=0 at N+1; new fetch granted at N+1 returns if_valid=1 at N+2.
REQ-042 Store d_we=1, d_addr=0x3000, d_wdata=0xDEADBEEF, d_size=2 -> mem_we=1, mem_din=0xDEADBEEF same cycle, d_valid=1 next cycle, mem_re=0.
REQ-043 RESET asserted the cycle after a load grant -> d_valid never asserted; after release, owner=NONE, starve_cnt=0.
